// File: rtl/uart_pkg.sv
// uart_pkg: frame types and helpers shared by the UART transmitter and receiver
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam int FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             wr_ok, rd_ok;

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr_ok = push && !full;
    assign rd_ok = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr_ok);
            rd_ptr <= rd_ptr + PW'(rd_ok);
            count  <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    // storage needs no reset: entries are only visible once counted
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8-O-1 UART transmitter
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 19_200,
    parameter int DEPTH    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       tx_out
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int BW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam int CW = $clog2(DEPTH+1);

    tx_state_t     state, state_d;
    logic [BW-1:0] baud_cnt, baud_cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shift_reg, shift_d, head;
    logic [CW-1:0] count;
    logic          parity, parity_d, tx_d, pop, empty, bit_end;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign busy    = count != '0 || state != IDLE;
    assign bit_end = baud_cnt == BW'(BIT_CYCLES - 1);

    always_comb begin
        state_d    = state;
        baud_cnt_d = (state == IDLE || bit_end) ? '0 : baud_cnt + BW'(1);
        bit_idx_d  = bit_idx;
        pop        = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end) begin
                         bit_idx_d = bit_idx + 3'd1;
                         if (bit_idx == 3'd7) state_d = PARITY;
                     end
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) begin
                         pop     = !empty;
                         state_d = IDLE;
                     end
            default: state_d = IDLE;
        endcase
        // popping always launches a new frame, from IDLE or straight after a stop bit
        if (pop) state_d = START;
        shift_d  = pop ? head : shift_reg;
        parity_d = pop ? odd_parity(head) : parity;
        tx_d     = state_d == START  ? 1'b0 :
                   state_d == DATA   ? shift_d[bit_idx_d] :
                   state_d == PARITY ? parity_d : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            parity    <= 1'b0;
            tx_out    <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            baud_cnt  <= baud_cnt_d;
            bit_idx   <= bit_idx_d;
            shift_reg <= shift_d;
            parity    <= parity_d;
            tx_out    <= tx_d;
            overflow  <= wr_en && full;
        end
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered asynchronous transmitter. Accepts bytes from on-board logic through a write strobe into an 8-deep FIFO, then serialises each byte as an 8-O-1 UART frame: 1 start bit, 8 data bits LSB first, odd parity, 1 stop bit. It is the transmit end of the board's serial link and produces the frame format the `rx` receiver expects. Unlike the unbuffered `tx`, it lets a producer issue bursts without polling `busy`.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 19_200: line rate in bit/s; `BIT_CYCLES = CLK_FREQ / BAUD` (integer division; 5208 at defaults).
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.
- `clk  in  1`: system clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `wr_en  in  1`: write strobe; one byte is accepted per cycle while high and not `full`.
- `wr_data  in  8`: byte to transmit, sampled when `wr_en` is high.
- `full  out  1`: FIFO holds `DEPTH` entries.
- `overflow  out  1`: one-cycle pulse when `wr_en` is high while `full`; the byte is dropped.
- `busy  out  1`: high when the FIFO is not empty or the FSM is not IDLE.
- `tx_out  out  1`: serial line; idles high.

## Operation
- FIFO: `count` ranges over 0..`DEPTH`. Read and write pointers are `$clog2(DEPTH)` bits wide and wrap naturally. `full` and `empty` decode from `count`.
- A write while `full` is dropped, even if a pop happens on the same edge. `count` is unchanged and `overflow` pulses.
- A write and a pop on the same edge, when not full: the write is stored, the pop happens, and `count` is unchanged.
- FSM states and transitions:
  - IDLE: go to START when the FIFO is not empty.
  - START → DATA → PARITY → STOP.
- Every state except IDLE lasts exactly `BIT_CYCLES` clocks, timed by `baud_cnt` counting 0..`BIT_CYCLES-1`. DATA lasts 8 × `BIT_CYCLES` and uses `bit_idx` 0..7.
- On entry to START, the head byte is popped into `shift_reg` and parity is computed as `~^byte` (odd parity: total number of ones in data plus parity is odd).
- At the end of STOP: go to START if the FIFO is not empty (back-to-back frames, no idle gap); otherwise go to IDLE.
- Line level per state: IDLE = 1, START = 0, DATA = `shift_reg[bit_idx]`, PARITY = parity bit, STOP = 1.
- `tx_out` is registered and updates on the same edge as the state and bit changes, so the line never glitches.

## Timing
- Reset values: `tx_out` = 1, `full` = 0, `overflow` = 0, `busy` = 0, FSM in IDLE, FIFO empty, counters 0.
- Reset assertion mid-frame aborts the frame immediately: `tx_out` goes high asynchronously and the FIFO contents are discarded.
- Latency: a write accepted at edge k into an empty FIFO with the FSM in IDLE pops at edge k+1. At that edge the state becomes START and `tx_out` falls.
- A frame occupies 11 × `BIT_CYCLES` clocks from the `tx_out` falling edge to the end of the stop bit.
- `busy` and `full` are registered or decoded from registered state only; they are valid in the cycle after the causing edge.
- `overflow` is registered: it is high for the one cycle following the rejected write edge.

## Structure
- Package `uart_pkg` holds:
  - `typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t`
  - `localparam int FRAME_BITS = 11`
  - `function odd_parity(logic [7:0])`
  The receiver side shares this package.
- Sub-module `sync_fifo` is parameterised by `WIDTH` and `DEPTH`, with ports `clk`, `rst_n`, `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`. It provides show-ahead `dout` (head visible while not empty).
- The top level contains the FSM, baud counter, bit index, shift register, and output registers.

## Test plan
Use `CLK_FREQ` = 16 and `BAUD` = 4 (`BIT_CYCLES` = 4) unless noted.

- Reset, then write 0x55 → `tx_out` falls 1 clock after the write. Line sequence, 4 clocks per bit: 0, 1,0,1,0,1,0,1,0, parity 1, stop 1. `busy` drops after 44 clocks.
- Write 0x01, 0x00, 0xFF on consecutive cycles → parity bits 0, 1, 1. The frames are contiguous: the stop bit is followed directly by the next start bit, for 132 clocks total.
- Write 10 bytes 0x10..0x19 on consecutive cycles from idle → `full` rises after the 9th write. The 10th write produces a single-cycle `overflow`. Bytes 0x10..0x18 are transmitted in order; 0x19 is never sent.
- Assert `rst_n` low during the DATA bit 3 of byte 0xA5, with 2 bytes queued → `tx_out` = 1 immediately. After release, `busy` = 0 and no frame is emitted.
- With `DEPTH` = 4, keep the FIFO at 3 entries while writing one byte on the same edge as each pop, for 20 frames → `count` stays constant across each push/pop edge, pointers wrap correctly, and the 20 bytes arrive in order without `overflow`.
- With the default parameters, write 0xC3 → each bit lasts exactly 5208 clocks and the frame totals 57288 clocks.
